// File: rtl/paddle_input_ctrl_pkg.sv
// Shared constants and debounce state encoding for the paddle input controller.
// Pure declarations; no latency.
// No flow control.
package paddle_input_ctrl_pkg;

    localparam int RIGHT_BORDER  = 799;
    localparam int BOTTOM_BORDER = 599;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } db_state_t;

    // Centre of an object from its top coordinate and height, widened so it never wraps.
    function automatic logic [11:0] center12(input logic [10:0] pos, input logic [8:0] size);
        logic [11:0] half;
        half = {3'b000, size} >> 1;
        return {1'b0, pos} + half;
    endfunction

endpackage

// File: rtl/paddle_input_ctrl_if.sv
// Button/tracker inputs and paddle command outputs of the paddle input controller.
// Wires only; no latency.
// No flow control: level commands and single-cycle pulses.
interface paddle_input_ctrl_if;
    logic        btnUpRaw;
    logic        btnDownRaw;
    logic        autoMode;
    logic        frameTick;
    logic [10:0] ballY;
    logic [8:0]  ballSize;
    logic [10:0] paddleY;
    logic [8:0]  paddleSize;
    logic        up;
    logic        down;
    logic        upPress;
    logic        downPress;

    modport master (
        input  btnUpRaw, btnDownRaw, autoMode, frameTick,
        input  ballY, ballSize, paddleY, paddleSize,
        output up, down, upPress, downPress
    );

    modport slave (
        output btnUpRaw, btnDownRaw, autoMode, frameTick,
        output ballY, ballSize, paddleY, paddleSize,
        input  up, down, upPress, downPress
    );
endinterface

// File: rtl/paddle_input_ctrl_debounce_fsm.sv
// Synchronizes one raw pushbutton and debounces it into a level plus a press pulse.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles from raw edge to level/press.
// No backpressure; any bounce restarts the stability count.
module debounce_fsm
    import paddle_input_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    db_state_t              state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   level_nxt, press_nxt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= '0;
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], raw};
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        press_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = ARM;
                    cnt_nxt   = '0;
                end
            end
            ARM: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end
            end
            RELEASE: begin
                if (s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/paddle_input_ctrl.sv
// Turns debounced buttons or a frame-paced ball tracker into exclusive up/down paddle commands.
// Latency: manual 1 cycle after debounced level; auto registered on frameTick.
// No backpressure; commands forced low on the cycle autoMode changes.
module paddle_input_ctrl
    import paddle_input_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int CNT_W           = 19,
    parameter int DEADBAND        = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    paddle_input_ctrl_if.master    pif
);

    localparam logic [11:0] DB_W = 12'(DEADBAND);

    logic        db_up, db_dn;
    logic        mode_q, mode_chg;
    logic        up_q, dn_q;
    logic [11:0] ball_c, pad_c;
    logic        auto_up, auto_dn;

    debounce_fsm #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_up (
        .clk   (clk),
        .reset (reset),
        .raw   (pif.btnUpRaw),
        .level (db_up),
        .press (pif.upPress)
    );

    debounce_fsm #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_dn (
        .clk   (clk),
        .reset (reset),
        .raw   (pif.btnDownRaw),
        .level (db_dn),
        .press (pif.downPress)
    );

    assign ball_c   = center12(pif.ballY, pif.ballSize);
    assign pad_c    = center12(pif.paddleY, pif.paddleSize);
    assign auto_up  = (ball_c + DB_W) < pad_c;
    assign auto_dn  = ball_c > (pad_c + DB_W);
    assign mode_chg = pif.autoMode != mode_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 1'b0;
            up_q   <= 1'b0;
            dn_q   <= 1'b0;
        end else begin
            mode_q <= pif.autoMode;
            if (!pif.autoMode) begin
                up_q <= db_up & ~db_dn;
                dn_q <= db_dn & ~db_up;
            end else if (mode_chg) begin
                // Entering auto: stay idle until the first tracker decision.
                up_q <= 1'b0;
                dn_q <= 1'b0;
            end else if (pif.frameTick) begin
                up_q <= auto_up;
                dn_q <= auto_dn & ~auto_up;
            end
        end
    end

    assign pif.up   = up_q & ~mode_chg;
    assign pif.down = dn_q & ~mode_chg;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed self-checking bench for paddle_input_ctrl with an 8-cycle debounce.
module tb_paddle_input_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    paddle_input_ctrl_if pif ();

    paddle_input_ctrl #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (4),
        .DEADBAND        (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        if ((pif.up & pif.down) !== 1'b0) begin
            errors++;
            $display("FAIL exclusive: up=%b down=%b, required not both 1", pif.up, pif.down);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        pif.frameTick = 1'b1;
        step(1);
        pif.frameTick = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int first;
        n = 0;
        first = 0;
        reset = 1'b0;
        pif.btnUpRaw = 1'b1;
        step(3);
        checks++;
        if (pif.up !== 1'b0) begin errors++; $display("FAIL reset_up: got %b want 0", pif.up); end
        checks++;
        if (pif.down !== 1'b0) begin errors++; $display("FAIL reset_down: got %b want 0", pif.down); end
        checks++;
        if (pif.upPress !== 1'b0) begin errors++; $display("FAIL reset_upPress: got %b want 0", pif.upPress); end
        checks++;
        if (pif.downPress !== 1'b0) begin errors++; $display("FAIL reset_downPress: got %b want 0", pif.downPress); end
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (pif.upPress === 1'b1) begin
                n++;
                if (first == 0) first = k;
            end
        end
        checks++;
        if (n != 1) begin errors++; $display("FAIL reset_press_count: got %0d want 1", n); end
        checks++;
        if (first < 9 || first > 12) begin errors++; $display("FAIL reset_press_latency: got %0d want 9..12", first); end
        checks++;
        if (pif.up !== 1'b1) begin errors++; $display("FAIL reset_up_after: got %b want 1", pif.up); end
    endtask

    task automatic test_bounce();
        int n;
        int first;
        n = 0;
        first = 0;
        pif.btnUpRaw = 1'b0;
        step(20);
        checks++;
        if (pif.up !== 1'b0) begin errors++; $display("FAIL bounce_released: got %b want 0", pif.up); end
        for (int i = 0; i < 30; i++) begin
            pif.btnUpRaw = ((i / 3) % 2 == 0);
            step(1);
            if (pif.upPress === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL bounce_no_press: got %0d presses want 0", n); end
        pif.btnUpRaw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (pif.upPress === 1'b1 && first == 0) first = k;
        end
        checks++;
        if (first < 9 || first > 11) begin errors++; $display("FAIL bounce_settle_latency: got %0d want 9..11", first); end
    endtask

    task automatic test_both();
        int first;
        first = 0;
        pif.btnDownRaw = 1'b1;
        step(20);
        checks++;
        if (pif.up !== 1'b0) begin errors++; $display("FAIL both_up: got %b want 0", pif.up); end
        checks++;
        if (pif.down !== 1'b0) begin errors++; $display("FAIL both_down: got %b want 0", pif.down); end
        pif.btnDownRaw = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step(1);
            if (pif.up === 1'b1 && first == 0) first = k;
        end
        checks++;
        if (first < 11 || first > 13) begin errors++; $display("FAIL both_release_latency: got %0d want 11..13", first); end
    endtask

    task automatic test_auto();
        int n;
        n = 0;
        pif.btnUpRaw = 1'b0;
        step(20);
        pif.autoMode   = 1'b1;
        pif.paddleY    = 11'd300;
        pif.paddleSize = 9'd80;
        pif.ballSize   = 9'd10;
        pif.ballY      = 11'd100;
        step(3);
        checks++;
        if ({pif.up, pif.down} !== 2'b00) begin errors++; $display("FAIL auto_before_tick: got %b%b want 00", pif.up, pif.down); end
        tick();
        checks++;
        if ({pif.up, pif.down} !== 2'b10) begin errors++; $display("FAIL auto_above: got %b%b want 10", pif.up, pif.down); end
        pif.ballY = 11'd336;
        tick();
        checks++;
        if ({pif.up, pif.down} !== 2'b00) begin errors++; $display("FAIL auto_deadband: got %b%b want 00", pif.up, pif.down); end
        pif.ballY = 11'd400;
        tick();
        checks++;
        if ({pif.up, pif.down} !== 2'b01) begin errors++; $display("FAIL auto_below: got %b%b want 01", pif.up, pif.down); end
        pif.ballY = 11'd100;
        step(4);
        checks++;
        if ({pif.up, pif.down} !== 2'b01) begin errors++; $display("FAIL auto_hold: got %b%b want 01", pif.up, pif.down); end
        pif.btnUpRaw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (pif.upPress === 1'b1) n++;
        end
        checks++;
        if (n != 1) begin errors++; $display("FAIL auto_upPress: got %0d want 1", n); end
        checks++;
        if ({pif.up, pif.down} !== 2'b01) begin errors++; $display("FAIL auto_ignores_buttons: got %b%b want 01", pif.up, pif.down); end
        tick();
        checks++;
        if ({pif.up, pif.down} !== 2'b10) begin errors++; $display("FAIL auto_next_tick: got %b%b want 10", pif.up, pif.down); end
        pif.btnUpRaw = 1'b0;
        step(20);
    endtask

    task automatic test_mode_toggle();
        pif.autoMode = 1'b0;
        #1;
        checks++;
        if (pif.up !== 1'b0) begin errors++; $display("FAIL mode_to_manual_cycle: up got %b want 0", pif.up); end
        pif.btnDownRaw = 1'b1;
        step(20);
        checks++;
        if ({pif.up, pif.down} !== 2'b01) begin errors++; $display("FAIL manual_down: got %b%b want 01", pif.up, pif.down); end
        pif.autoMode = 1'b1;
        #1;
        checks++;
        if (pif.down !== 1'b0) begin errors++; $display("FAIL mode_change_cycle: down got %b want 0", pif.down); end
        step(4);
        checks++;
        if ({pif.up, pif.down} !== 2'b00) begin errors++; $display("FAIL mode_wait_tick: got %b%b want 00", pif.up, pif.down); end
        pif.ballY = 11'd100;
        tick();
        checks++;
        if ({pif.up, pif.down} !== 2'b10) begin errors++; $display("FAIL mode_auto_tick: got %b%b want 10", pif.up, pif.down); end
    endtask

    task automatic test_back_to_back();
        pif.autoMode = 1'b0;
        #1;
        checks++;
        if ({pif.up, pif.down} !== 2'b00) begin errors++; $display("FAIL resume_change_cycle: got %b%b want 00", pif.up, pif.down); end
        step(1);
        checks++;
        if ({pif.up, pif.down} !== 2'b01) begin errors++; $display("FAIL resume_manual: got %b%b want 01", pif.up, pif.down); end
    endtask

    task automatic test_reset_mid();
        int n;
        int first;
        n = 0;
        first = 0;
        reset = 1'b0;
        #1;
        checks++;
        if (pif.down !== 1'b0) begin errors++; $display("FAIL midreset_down: got %b want 0", pif.down); end
        step(2);
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (pif.downPress === 1'b1) begin
                n++;
                if (first == 0) first = k;
            end
        end
        checks++;
        if (n != 1) begin errors++; $display("FAIL midreset_press_count: got %0d want 1", n); end
        checks++;
        if (first < 9 || first > 12) begin errors++; $display("FAIL midreset_latency: got %0d want 9..12", first); end
        checks++;
        if (pif.down !== 1'b1) begin errors++; $display("FAIL midreset_down_after: got %b want 1", pif.down); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b0;
        pif.btnUpRaw   = 1'b0;
        pif.btnDownRaw = 1'b0;
        pif.autoMode   = 1'b0;
        pif.frameTick  = 1'b0;
        pif.ballY      = 11'd0;
        pif.ballSize   = 9'd0;
        pif.paddleY    = 11'd0;
        pif.paddleSize = 9'd0;
        test_reset();
        test_bounce();
        test_both();
        test_auto();
        test_mode_toggle();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
